// File: rtl/number_encoder_serializer.sv
// JPEG coefficient encoder: converts a signed coefficient into its size category
// and magnitude code, then shifts the code out MSB-first over a valid/ready link.
module number_encoder_serializer #(
    parameter int DECODED_NUMBER_WIDTH = 12,
    parameter int CODED_NUMBER_WIDTH   = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DECODED_NUMBER_WIDTH-1:0] in_number,
    output logic                          cat_valid,
    output logic [3:0]                    s_value,
    output logic [CODED_NUMBER_WIDTH-1:0] coded_number,
    output logic                          bit_out,
    output logic                          bit_valid,
    input  logic                          bit_ready,
    output logic                          bit_last,
    output logic                          busy
);

    localparam int DNW = DECODED_NUMBER_WIDTH;
    localparam int CNW = CODED_NUMBER_WIDTH;
    localparam logic [DNW-1:0] MAX_MAG = DNW'((1 << CNW) - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       s_q, s_d;
    logic [CNW-1:0]   coded_q, coded_d;
    logic             cat_valid_q, cat_valid_d;
    logic [3:0]       enc_s_s;
    logic [CNW-1:0]   enc_code_s;
    logic [3:0]       bit_idx_s;
    logic [CNW-1:0]   shifted_s;
    logic             accept_s;

    // Returns {size category, code}; the most negative input and oversize magnitudes clamp
    function automatic logic [4+CNW-1:0] encode(input logic [DNW-1:0] v);
        logic [DNW-1:0] mag;
        logic [CNW-1:0] m;
        logic [CNW-1:0] mask;
        logic [CNW-1:0] code;
        logic [3:0]     s;
        if (v[DNW-1]) begin
            mag = ~v + {{(DNW-1){1'b0}}, 1'b1};
        end else begin
            mag = v;
        end
        if (mag > MAX_MAG) begin
            m = {CNW{1'b1}};
        end else begin
            m = mag[CNW-1:0];
        end
        s = 4'd0;
        for (int i = 0; i < CNW; i++) begin
            if (m[i]) begin
                s = 4'(i + 1);
            end else begin
                s = s;
            end
        end
        mask = ~({CNW{1'b1}} << s);
        if (v[DNW-1]) begin
            code = ~m & mask;
        end else begin
            code = m;
        end
        return {s, code};
    endfunction

    assign {enc_s_s, enc_code_s} = encode(in_number);
    assign accept_s  = in_valid && in_ready;
    assign bit_idx_s = cnt_q - 4'd1;
    assign shifted_s = coded_q >> bit_idx_s;

    assign in_ready     = (state_q == ST_IDLE) && !rst;
    assign busy         = (state_q == ST_EMIT);
    assign bit_valid    = (state_q == ST_EMIT);
    assign bit_last     = (state_q == ST_EMIT) && (cnt_q == 4'd1);
    assign bit_out      = (state_q == ST_EMIT) && shifted_s[0];
    assign cat_valid    = cat_valid_q;
    assign s_value      = s_q;
    assign coded_number = coded_q;

    // Next-state logic: capture on accept, count bits down while emitting
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        coded_d     = coded_q;
        cat_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    s_d         = enc_s_s;
                    coded_d     = enc_code_s;
                    cat_valid_d = 1'b1;
                    if (enc_s_s != 4'd0) begin
                        state_d = ST_EMIT;
                        cnt_d   = enc_s_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (bit_ready) begin
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            s_q         <= 4'd0;
            coded_q     <= {CNW{1'b0}};
            cat_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            coded_q     <= coded_d;
            cat_valid_q <= cat_valid_d;
        end
    end

endmodule

// File: tb/tb_number_encoder_serializer.sv
// Directed, table-driven bench for number_encoder_serializer with hand-computed codes.
module tb_number_encoder_serializer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_number;
    logic        cat_valid;
    logic [3:0]  s_value;
    logic [10:0] coded_number;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic        bit_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] num;
        logic [3:0]  s;
        logic [10:0] code;
    } vec_t;

    vec_t vecs [16];

    number_encoder_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_number    (in_number),
        .cat_valid    (cat_valid),
        .s_value      (s_value),
        .coded_number (coded_number),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .bit_last     (bit_last),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Send one number and drain its code with bit_ready held high.
    task automatic send_and_drain(input vec_t v);
        wait_ready();
        in_valid  = 1'b1;
        in_number = v.num;
        bit_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("cat_valid", 32'(cat_valid), 32'd1);
        chk("s_value", 32'(s_value), 32'(v.s));
        chk("coded_number", 32'(coded_number), 32'(v.code));
        for (int k = int'(v.s) - 1; k >= 0; k--) begin
            chk("bit_valid", 32'(bit_valid), 32'd1);
            chk("bit_out", 32'(bit_out), 32'(v.code[k]));
            chk("bit_last", 32'(bit_last), 32'(k == 0));
            chk("in_ready_emit", 32'(in_ready), 32'd0);
            tick();
        end
        chk("bit_valid_done", 32'(bit_valid), 32'd0);
        chk("in_ready_done", 32'(in_ready), 32'd1);
        chk("cat_valid_done", 32'(cat_valid), 32'd0);
    endtask

    initial begin
        int k;
        logic [5:0] pat;
        vecs[0]  = '{12'h005, 4'd3,  11'h005};
        vecs[1]  = '{12'hFFC, 4'd3,  11'h003};
        vecs[2]  = '{12'hFFF, 4'd1,  11'h000};
        vecs[3]  = '{12'h001, 4'd1,  11'h001};
        vecs[4]  = '{12'h7FF, 4'd11, 11'h7FF};
        vecs[5]  = '{12'h801, 4'd11, 11'h000};
        vecs[6]  = '{12'h800, 4'd11, 11'h000};
        vecs[7]  = '{12'h3FF, 4'd10, 11'h3FF};
        vecs[8]  = '{12'hC01, 4'd10, 11'h000};
        vecs[9]  = '{12'hFFD, 4'd2,  11'h000};
        vecs[10] = '{12'h006, 4'd3,  11'h006};
        vecs[11] = '{12'hFFA, 4'd3,  11'h001};
        vecs[12] = '{12'h064, 4'd7,  11'h064};
        vecs[13] = '{12'hF9C, 4'd7,  11'h01B};
        vecs[14] = '{12'h7D0, 4'd11, 11'h7D0};
        vecs[15] = '{12'h830, 4'd11, 11'h02F};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_number = 12'h000;
        bit_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_cat_valid", 32'(cat_valid), 32'd0);
        chk("rst_s_value", 32'(s_value), 32'd0);
        chk("rst_coded", 32'(coded_number), 32'd0);
        chk("rst_bit_valid", 32'(bit_valid), 32'd0);
        chk("rst_bit_out", 32'(bit_out), 32'd0);
        chk("rst_bit_last", 32'(bit_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        for (int i = 0; i < 16; i++) begin
            send_and_drain(vecs[i]);
        end

        // Back-to-back zeros are accepted every cycle without emitting bits
        in_valid  = 1'b1;
        in_number = 12'h000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("zero_cat_valid", 32'(cat_valid), 32'd1);
            chk("zero_s_value", 32'(s_value), 32'd0);
            chk("zero_coded", 32'(coded_number), 32'd0);
            chk("zero_bit_valid", 32'(bit_valid), 32'd0);
            chk("zero_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("zero_cat_valid_end", 32'(cat_valid), 32'd0);

        // +6 with a stalling receiver; a pending in_number must be ignored
        wait_ready();
        in_valid  = 1'b1;
        in_number = 12'h006;
        bit_ready = 1'b0;
        tick();
        in_number = 12'h7FF;
        chk("stall_cat_valid", 32'(cat_valid), 32'd1);
        pat = 6'b110010;
        k = 2;
        for (int i = 0; i < 6; i++) begin
            chk("stall_bit_valid", 32'(bit_valid), 32'd1);
            chk("stall_bit_out", 32'(bit_out), 32'(3'b110 >> k) & 32'd1);
            chk("stall_bit_last", 32'(bit_last), 32'(k == 0));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_s_hold", 32'(s_value), 32'd3);
            bit_ready = pat[i];
            tick();
            if (pat[i]) k--;
        end
        chk("stall_bit_valid_end", 32'(bit_valid), 32'd0);
        chk("stall_in_ready_end", 32'(in_ready), 32'd1);
        in_valid  = 1'b0;
        bit_ready = 1'b0;
        tick();

        // +1023 abandoned by reset after four bits
        wait_ready();
        in_valid  = 1'b1;
        in_number = 12'h3FF;
        bit_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_bit_out", 32'(bit_out), 32'd1);
            chk("abort_bit_last", 32'(bit_last), 32'd0);
            tick();
        end
        rst = 1'b1;
        #1;
        chk("abort_in_ready_rst", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_bit_valid", 32'(bit_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bit_out0", 32'(bit_out), 32'd0);
        chk("abort_bit_last0", 32'(bit_last), 32'd0);
        chk("abort_s_value", 32'(s_value), 32'd0);
        chk("abort_coded", 32'(coded_number), 32'd0);
        chk("abort_cat_valid", 32'(cat_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        send_and_drain(vecs[2]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
